// File: rtl/mod25519_req_arbiter.sv
// Round-robin front end sharing one seq_mod_25519 reducer among NREQ requesters.
// Accepts one operand at a time, sequences start/done, returns the tagged result.
module mod25519_req_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*512-1:0]  req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [255:0]         rsp_mod,
    output logic                 red_start,
    output logic [511:0]         red_x,
    input  logic                 red_done,
    input  logic [255:0]         red_mod,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [2:0]     state_q,   state_d;
    logic [IDW-1:0] rr_ptr_q,  rr_ptr_d;
    logic [IDW-1:0] id_q,      id_d;
    logic [511:0]   red_x_q,   red_x_d;
    logic [255:0]   rsp_mod_q, rsp_mod_d;
    logic [IDW-1:0] rsp_id_q,  rsp_id_d;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDW-1:0]    grant_off;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    rr_next;
    logic [IDW:0]      grant_sum;
    logic [IDW:0]      next_sum;
    logic              grant_vld;
    logic              accept;

    // Rotate the request vector so rr_ptr sits at bit 0; the lowest set bit
    // of the rotated vector is the round-robin winner.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        grant_vld = 1'b0;
        grant_off = '0;
        req_dbl   = {req_valid, req_valid} >> rr_ptr_q;
        req_rot   = req_dbl[NREQ-1:0];
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_vld = 1'b1;
                grant_off = IDW'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        grant_idx = (grant_sum >= NREQ_W) ? IDW'(grant_sum - NREQ_W) : grant_sum[IDW-1:0];
        next_sum  = {1'b0, grant_idx} + (IDW+1)'(1);
        rr_next   = (next_sum >= NREQ_W) ? '0 : next_sum[IDW-1:0];
    end

    // The reducer keeps running through our reset, so a grant also needs red_done.
    assign accept    = (state_q == S_IDLE) && red_done && grant_vld;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        red_x_d   = red_x_q;
        rsp_mod_d = rsp_mod_q;
        rsp_id_d  = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant_idx == IDW'(i)) red_x_d = req_x[i*512 +: 512];
                    end
                    id_d     = grant_idx;
                    rr_ptr_d = rr_next;
                    state_d  = S_START;
                end
            end
            S_START: state_d = S_GUARD;
            // red_done may still show the previous idle level here.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (red_done) begin
                    rsp_mod_d = red_mod;
                    rsp_id_d  = id_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            red_x_q   <= '0;
            rsp_mod_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            red_x_q   <= red_x_d;
            rsp_mod_q <= rsp_mod_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign red_start = (state_q == S_START);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign red_x     = red_x_q;
    assign rsp_mod   = rsp_mod_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mod25519_req_arbiter.sv
// Bench for mod25519_req_arbiter: behavioural 11-cycle reducer, requester models,
// and a scoreboard of {id, x mod p} pushed on accept and popped on response.
module tb_mod25519_req_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam logic [511:0] P = (512'd1 << 255) - 512'd19;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [255:0]   mod;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*512-1:0] req_x = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [255:0]        rsp_mod;
    logic                red_start;
    logic [511:0]        red_x;
    logic                red_done;
    logic [255:0]        red_mod;
    logic                busy;

    mod25519_req_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_mod(rsp_mod),
        .red_start(red_start), .red_x(red_x), .red_done(red_done), .red_mod(red_mod),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reducer model: idle when count is zero, done 11 cycles after start is sampled.
    logic [3:0]   red_cnt = 4'd0;
    logic [255:0] red_res = '0;
    logic         hold_busy = 1'b0;
    assign red_done = (red_cnt == 4'd0) && !hold_busy;
    assign red_mod  = red_res;
    always @(posedge clk) begin
        if (red_start && red_cnt == 4'd0) begin
            red_cnt <= 4'd11;
            red_res <= 256'(red_x % P);
        end else if (red_cnt != 4'd0) begin
            red_cnt <= red_cnt - 4'd1;
        end
    end

    // A requester is valid while it has issued more operands than were accepted.
    int set_seq [NREQ];
    int done_seq[NREQ];
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) req_valid[i] = (set_seq[i] != done_seq[i]);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    exp_t         sb[$];
    int           acc_log[$];
    int           start_log[$];
    int           cyc = 0, acc_cyc = 0, hs_cyc = 0;
    int           n_acc = 0, n_rsp = 0, n_start = 0, starts = 0;
    logic [511:0] acc_x = '0;
    logic [IDW-1:0] last_id = '0;
    logic [255:0] last_mod = '0;

    // Monitor: samples on the falling edge, retires handshakes after the rising edge.
    initial begin
        logic [NREQ-1:0] hs;
        logic            prev_valid, prev_hold;
        logic [255:0]    prev_mod;
        logic [IDW-1:0]  prev_id;
        int              gid;
        exp_t            e;
        prev_valid = 1'b0; prev_hold = 1'b0; prev_mod = '0; prev_id = '0;
        forever begin
            @(negedge clk);
            cyc++;
            hs = '0;
            if (rst) begin
                sb.delete();
                prev_valid = 1'b0;
                prev_hold  = 1'b0;
            end else begin
                hs = req_valid & req_ready;
                if (req_ready != '0) begin
                    check("rdy_onehot", 512'($countones(req_ready)), 512'd1);
                    check("rdy_only_valid", 512'(req_ready & ~req_valid), 512'd0);
                    check("grant_needs_done", 512'(red_done), 512'd1);
                end
                if (hs != '0) begin
                    gid = 0;
                    for (int i = 0; i < NREQ; i++) if (hs[i]) gid = i;
                    acc_x = req_x[gid*512 +: 512];
                    sb.push_back('{id: IDW'(gid), mod: 256'(acc_x % P)});
                    acc_log.push_back(gid);
                    acc_cyc = cyc;
                    n_acc++;
                    starts = 0;
                end
                if (red_start) begin
                    check("start_x", red_x, acc_x);
                    check("start_done", 512'(red_done), 512'd1);
                    starts++;
                    n_start++;
                    start_log.push_back(cyc);
                end
                if (prev_hold) begin
                    check("hold_valid", 512'(rsp_valid), 512'd1);
                    check("hold_mod", 512'(rsp_mod), 512'(prev_mod));
                    check("hold_id", 512'(rsp_id), 512'(prev_id));
                end
                if (rsp_valid) check("rsp_quiet", 512'({req_ready, red_start}), 512'd0);
                if (rsp_valid && !prev_valid) begin
                    check("latency", 512'(cyc - acc_cyc), 512'd14);
                    check("one_start", 512'(starts), 512'd1);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 512'd1, 512'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", 512'(rsp_id), 512'(e.id));
                        check("rsp_mod", 512'(rsp_mod), 512'(e.mod));
                    end
                    last_id  = rsp_id;
                    last_mod = rsp_mod;
                    hs_cyc   = cyc;
                    n_rsp++;
                end
                prev_hold  = rsp_valid && !rsp_ready;
                prev_valid = rsp_valid;
                prev_mod   = rsp_mod;
                prev_id    = rsp_id;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) if (hs[i]) done_seq[i]++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic issue(input int i, input logic [511:0] x);
        req_x[i*512 +: 512] = x;
        set_seq[i] = done_seq[i] + 1;
    endtask

    task automatic cancel_all();
        for (int i = 0; i < NREQ; i++) set_seq[i] = done_seq[i];
    endtask

    task automatic wait_acc(input int target);
        int c = 0;
        while (n_acc < target && c < 300) begin step(1); c++; end
        check("acc_timeout", 512'(n_acc >= target), 512'd1);
    endtask

    task automatic wait_rsp(input int target);
        int c = 0;
        while (n_rsp < target && c < 300) begin step(1); c++; end
        check("rsp_timeout", 512'(n_rsp >= target), 512'd1);
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!rsp_valid && c < 300) begin step(1); c++; end
        check("valid_timeout", 512'(rsp_valid), 512'd1);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 512'({req_ready, rsp_valid, red_start, busy, rsp_id}), 512'd0);
        check({tag, "_red_x"}, red_x, 512'd0);
        check({tag, "_rsp_mod"}, 512'(rsp_mod), 512'd0);
    endtask

    initial begin
        int a0, s0, b4, nr;
        int ord[5] = '{0, 1, 2, 3, 0};

        // Reset values
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");

        // Single request on lane 2: 2^255 reduces to 19
        step(1);
        issue(2, 512'd1 << 255);
        wait_rsp(1);
        check("t1_acc_id", 512'(acc_log[0]), 512'd2);
        check("t1_id", 512'(last_id), 512'd2);
        check("t1_mod", 512'(last_mod), 512'd19);

        // 2^256 -> 38 on lane 0, 5 -> 5 on lane 1
        issue(0, 512'd1 << 256);
        wait_rsp(2);
        check("t2a_id", 512'(last_id), 512'd0);
        check("t2a_mod", 512'(last_mod), 512'd38);
        issue(1, 512'd5);
        wait_rsp(3);
        check("t2b_id", 512'(last_id), 512'd1);
        check("t2b_mod", 512'(last_mod), 512'd5);

        // All four valid from reset: order 0,1,2,3,0 with starts 15 cycles apart
        step(1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        a0 = acc_log.size();
        s0 = start_log.size();
        nr = n_rsp;
        for (int i = 0; i < NREQ; i++) issue(i, rand512());
        wait_acc(n_acc + 1);
        issue(0, rand512());
        wait_rsp(nr + 5);
        for (int k = 0; k < 5; k++) check("t3_order", 512'(acc_log[a0+k]), 512'(ord[k]));
        for (int k = 0; k < 4; k++)
            check("t3_spacing", 512'(start_log[s0+k+1] - start_log[s0+k]), 512'd15);

        // Back-pressure in RESP, then regrant one cycle after the handshake
        rsp_ready = 1'b0;
        issue(3, rand512());
        wait_valid();
        b4 = n_acc;
        nr = n_rsp;
        issue(0, rand512());
        step(20);
        check("t4_no_acc", 512'(n_acc), 512'(b4));
        check("t4_still_valid", 512'(rsp_valid), 512'd1);
        rsp_ready = 1'b1;
        wait_acc(b4 + 1);
        check("t4_regrant", 512'(acc_cyc - hs_cyc), 512'd1);
        check("t4_grant_id", 512'(acc_log[acc_log.size()-1]), 512'd0);
        wait_rsp(nr + 2);

        // Reset during WAIT, reducer held busy for 5 cycles afterwards
        nr = n_rsp;
        b4 = n_start;
        issue(0, rand512());
        begin
            int c = 0;
            while (n_start == b4 && c < 50) begin step(1); c++; end
        end
        step(4);
        rst = 1'b1;
        cancel_all();
        step(2);
        hold_busy = 1'b1;
        rst = 1'b0;
        b4 = n_acc;
        issue(1, rand512());
        repeat (5) begin
            @(negedge clk);
            check_reset_outputs("t5");
        end
        check("t5_no_grant", 512'(n_acc), 512'(b4));
        step(1);
        hold_busy = 1'b0;
        wait_rsp(nr + 1);
        check("t5_id", 512'(last_id), 512'd1);

        // Wrap: lane 2 leaves rr_ptr at 3, lone lane 1 wins, then rr_ptr is 2
        nr = n_rsp;
        issue(2, rand512());
        wait_rsp(nr + 1);
        issue(1, rand512());
        wait_rsp(nr + 2);
        check("t6_wrap", 512'(acc_log[acc_log.size()-1]), 512'd1);
        issue(1, rand512());
        issue(2, rand512());
        wait_rsp(nr + 4);
        check("t6_ptr_first", 512'(acc_log[acc_log.size()-2]), 512'd2);
        check("t6_ptr_second", 512'(acc_log[acc_log.size()-1]), 512'd1);
        check("sb_drained", 512'(sb.size()), 512'd0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
